// File: rtl/sha_core.sv
// SHA-256 compression engine: one round per cycle, digest-vs-target compare.
// Define SHA_DOUBLE_EN to run a second compression over the first digest (double SHA-256).
module sha_core #(
  parameter int ROUNDS = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         beginSHA,
  input  logic [511:0] block,
  input  logic [255:0] target,
  output logic         complete,
  output logic         valid,
  output logic [255:0] hash,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_t;

  localparam int CW = 7;
  localparam logic [CW-1:0] LAST = CW'(ROUNDS - 1);

  localparam logic [255:0] IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

  localparam logic [31:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  function automatic logic [31:0] ror(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return ror(x, 2) ^ ror(x, 13) ^ ror(x, 22);
  endfunction

  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return ror(x, 6) ^ ror(x, 11) ^ ror(x, 25);
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
  endfunction

  state_t          state_q, state_d;
  logic [CW-1:0]   rcnt_q;
  logic [255:0]    hash_q;
  logic            valid_q;
  logic            last_pass;

  logic [31:0]     w_q  [16];   // w_q[0] is the word consumed this round
  logic [31:0]     st_q [8];    // a..h
  logic [31:0]     st_d [8];
  logic [255:0]    target_q;
  logic [31:0]     w_new, t1, t2;
  logic [255:0]    digest;

`ifdef SHA_DOUBLE_EN
  logic            pass_q;
  assign last_pass = pass_q;
`else
  assign last_pass = 1'b1;
`endif

  always_comb begin
    // NOTE: every combinational output gets a default first, so no latch can be inferred.
    state_d = state_q;
    case (state_q)
      IDLE:    if (beginSHA) state_d = ROUND;
      ROUND:   if (rcnt_q == LAST) state_d = FINAL;
      FINAL:   state_d = last_pass ? DONE : ROUND;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    t1 = st_q[7] + bsig1(st_q[4]) + ((st_q[4] & st_q[5]) ^ (~st_q[4] & st_q[6]))
       + K[rcnt_q[5:0]] + w_q[0];
    t2 = bsig0(st_q[0]) + ((st_q[0] & st_q[1]) ^ (st_q[0] & st_q[2]) ^ (st_q[1] & st_q[2]));
    st_d[0] = t1 + t2;
    st_d[1] = st_q[0];
    st_d[2] = st_q[1];
    st_d[3] = st_q[2];
    st_d[4] = st_q[3] + t1;
    st_d[5] = st_q[4];
    st_d[6] = st_q[5];
    st_d[7] = st_q[6];
    w_new   = ssig1(w_q[14]) + w_q[9] + ssig0(w_q[1]) + w_q[0];
    digest  = '0;
    for (int i = 0; i < 8; i++) digest[255-32*i -: 32] = IV[255-32*i -: 32] + st_q[i];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rcnt_q  <= '0;
      hash_q  <= '0;
      valid_q <= 1'b0;
`ifdef SHA_DOUBLE_EN
      pass_q  <= 1'b0;
`endif
    end else begin
      // NOTE: sequential state is written with non-blocking assignments only.
      state_q <= state_d;
      case (state_q)
        IDLE: if (beginSHA) begin
          rcnt_q  <= '0;
          valid_q <= 1'b0;
`ifdef SHA_DOUBLE_EN
          pass_q  <= 1'b0;
`endif
        end
        ROUND: rcnt_q <= (rcnt_q == LAST) ? '0 : rcnt_q + 1'b1;
        FINAL: begin
          rcnt_q <= '0;
          if (last_pass) begin
            hash_q  <= digest;
            valid_q <= (digest < target_q);
          end
`ifdef SHA_DOUBLE_EN
          pass_q <= 1'b1;
`endif
        end
        default: ;
      endcase
    end
  end

  // NOTE: datapath storage has no reset; every word is loaded on accept before it is read.
  always_ff @(posedge clk) begin
    case (state_q)
      IDLE: if (beginSHA) begin
        for (int i = 0; i < 16; i++) w_q[i] <= block[511-32*i -: 32];
        for (int i = 0; i < 8; i++) st_q[i] <= IV[255-32*i -: 32];
        target_q <= target;
      end
      ROUND: begin
        for (int i = 0; i < 15; i++) w_q[i] <= w_q[i+1];
        w_q[15] <= w_new;
        for (int i = 0; i < 8; i++) st_q[i] <= st_d[i];
      end
`ifdef SHA_DOUBLE_EN
      FINAL: if (!pass_q) begin
        // Second pass hashes the 32-byte first digest as a padded one-block message.
        for (int i = 0; i < 8; i++) w_q[i] <= digest[255-32*i -: 32];
        w_q[8] <= 32'h80000000;
        for (int i = 9; i < 15; i++) w_q[i] <= 32'h0;
        w_q[15] <= 32'h00000100;
        for (int i = 0; i < 8; i++) st_q[i] <= IV[255-32*i -: 32];
      end
`endif
      default: ;
    endcase
  end

  assign complete = (state_q == DONE);
  assign busy     = (state_q == ROUND) || (state_q == FINAL);
  assign hash     = hash_q;
  assign valid    = valid_q;

endmodule

// File: tb/tb_sha_core.sv
// Scoreboard bench for sha_core: stimulus pushes expected digests, a monitor checks each complete.
// Expected values follow SHA_DOUBLE_EN when it is defined.
module tb_sha_core;

`ifdef SHA_DOUBLE_EN
  localparam int LAT = 130;
  localparam logic [255:0] H_ABC   = 256'h4f8b42c22dd3729b519ba6f68d2da7cc5b2d606d05daed5ad5128cc03e6c6358;
  localparam logic [255:0] H_EMPTY = 256'h5df6e0e2761359d30a8275058e299fcc0381534545f55cf43e41983f5d4c9456;
`else
  localparam int LAT = 65;
  localparam logic [255:0] H_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] H_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
`endif
  localparam logic [511:0] B_ABC   = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] B_EMPTY = {32'h80000000, 480'h0};
  localparam logic [255:0] ONES    = '1;

  typedef struct {
    logic [255:0] hash;
    logic         valid;
    int           acc_cyc;
  } exp_t;

  logic         clk, rst, beginSHA;
  logic [511:0] block;
  logic [255:0] target;
  logic         complete, valid, busy;
  logic [255:0] hash;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   n_done = 0;

  sha_core #(.ROUNDS(64)) dut (
    .clk(clk), .rst(rst), .beginSHA(beginSHA), .block(block), .target(target),
    .complete(complete), .valid(valid), .hash(hash), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: every complete pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && complete) begin
      n_done++;
      if (sb.size() == 0) begin
        check("unexpected_complete", 256'(1), 256'(0));
      end else begin
        e = sb.pop_front();
        check("hash", hash, e.hash);
        check("valid", 256'(valid), 256'(e.valid));
        check("latency", 256'(cyc - e.acc_cyc), 256'(LAT));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [511:0] blk, input logic [255:0] tgt,
                           input logic [255:0] exp_h, input logic exp_v, input bit push);
    exp_t e;
    block    = blk;
    target   = tgt;
    beginSHA = 1'b1;
    if (push) begin
      e.hash = exp_h; e.valid = exp_v; e.acc_cyc = cyc + 1;
      sb.push_back(e);
    end
    step();
    beginSHA = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!complete && n < LAT + 20) begin
      step();
      n++;
    end
    check({name, "_done"}, 256'(complete), 256'(1));
  endtask

  initial begin
    logic [255:0] abc_p1;
    int d0, n;
    abc_p1   = H_ABC + 256'd1;
    rst      = 1'b1;
    beginSHA = 1'b0;
    block    = '0;
    target   = '0;
    repeat (3) step();
    check("rst_complete", 256'(complete), 256'(0));
    check("rst_valid", 256'(valid), 256'(0));
    check("rst_hash", hash, 256'(0));
    check("rst_busy", 256'(busy), 256'(0));
    rst = 1'b0;
    repeat (10) step();
    check("idle_no_complete", 256'(n_done), 256'(0));

    // abc against all-ones, then the compare boundaries
    start_job(B_ABC, ONES, H_ABC, 1'b1, 1'b1);   wait_done("abc");    step();
    start_job(B_ABC, H_ABC, H_ABC, 1'b0, 1'b1);  wait_done("eq");     step();
    start_job(B_ABC, abc_p1, H_ABC, 1'b1, 1'b1); wait_done("plus1");  step();
    start_job(B_ABC, '0, H_ABC, 1'b0, 1'b1);     wait_done("zero");   step();

    // busy ignore: extra strobes at cycles 10, 30 and on DONE
    d0 = n_done;
    start_job(B_ABC, ONES, H_ABC, 1'b1, 1'b1);
    n = 0;
    while (!complete && n < LAT + 20) begin
      check("busy_high", 256'(busy), 256'(1));
      beginSHA = (n == 10 || n == 30);
      step();
      n++;
    end
    check("busy_done_seen", 256'(complete), 256'(1));
    check("busy_low_in_done", 256'(busy), 256'(0));
    beginSHA = 1'b1;
    step();
    beginSHA = 1'b0;
    repeat (LAT + 20) step();
    check("busy_single_complete", 256'(n_done - d0), 256'(1));

    // reset in the middle of round 40
    d0 = n_done;
    start_job(B_ABC, ONES, H_ABC, 1'b1, 1'b0);
    repeat (41) step();
    rst = 1'b1;
    #1;
    check("midrst_hash", hash, 256'(0));
    check("midrst_valid", 256'(valid), 256'(0));
    check("midrst_busy", 256'(busy), 256'(0));
    check("midrst_complete", 256'(complete), 256'(0));
    step();
    rst = 1'b0;
    repeat (LAT) step();
    check("midrst_no_stale", 256'(n_done - d0), 256'(0));
    start_job(B_ABC, ONES, H_ABC, 1'b1, 1'b1);
    wait_done("after_rst");
    step();

    // hold: inputs toggled during the job, results held for 20 cycles
    start_job(B_ABC, ONES, H_ABC, 1'b1, 1'b1);
    repeat (5) step();
    block  = {16{32'hdeadbeef}};
    target = '0;
    wait_done("hold");
    for (int i = 0; i < 20; i++) begin
      step();
      check("hold_hash", hash, H_ABC);
      check("hold_valid", 256'(valid), 256'(1));
    end

    // back-to-back: next job starts on the first IDLE cycle after DONE
    start_job(B_EMPTY, ONES, H_EMPTY, 1'b1, 1'b1);
    wait_done("empty");
    step();
    start_job(B_ABC, '0, H_ABC, 1'b0, 1'b1);
    check("b2b_valid_cleared", 256'(valid), 256'(0));
    check("b2b_hash_kept", hash, H_EMPTY);
    wait_done("b2b");
    repeat (5) step();
    check("scoreboard_empty", 256'(sb.size()), 256'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
